// File: rtl/tick_rate_ctrl.sv
// Selectable-rate tick generator (/1, /2, /10, /50) with acknowledged rate changes.
// Optional tick counter output enabled by defining TICK_RATE_CTRL_TICK_CNT_EN.
module tick_rate_ctrl #(
    parameter int TICK_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sel_req,
    input  logic [1:0]        sel_rate,
    output logic              sel_ack,
    output logic              tick,
    output logic [1:0]        cur_rate,
    output logic              busy
`ifdef TICK_RATE_CTRL_TICK_CNT_EN
    ,
    output logic [TICK_W-1:0] tick_cnt
`endif
);

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    logic [1:0] cur_rate_q, cur_rate_d;
    logic [1:0] pend_q, pend_d;
    logic       tick_q, tick_d;
    logic       sel_ack_q, sel_ack_d;
    logic       busy_q, busy_d;

    function automatic logic [5:0] last_cnt(input logic [1:0] rate);
        case (rate)
            2'd0:    last_cnt = 6'd0;
            2'd1:    last_cnt = 6'd1;
            2'd2:    last_cnt = 6'd9;
            default: last_cnt = 6'd49;
        endcase
    endfunction

    logic       wrap;
    logic       req_ok;
    logic [5:0] cnt_next;

    always_comb begin
        wrap     = (cnt_q == last_cnt(cur_rate_q));
        cnt_next = wrap ? 6'd0 : cnt_q + 6'd1;
        // A request still held during its own acknowledge cycle must not be taken twice.
        req_ok   = sel_req && !sel_ack_q;

        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_rate_d = cur_rate_q;
        pend_d     = pend_q;
        tick_d     = 1'b0;
        sel_ack_d  = 1'b0;
        busy_d     = busy_q;

        case (state_q)
            STOP: begin
                cnt_d  = '0;
                busy_d = 1'b0;
                if (req_ok) begin
                    cur_rate_d = sel_rate;
                    sel_ack_d  = 1'b1;
                end
                if (en) state_d = RUN;
            end
            RUN: begin
                if (!en) begin
                    state_d = STOP;
                    cnt_d   = '0;
                end else begin
                    cnt_d  = cnt_next;
                    tick_d = wrap;
                    if (req_ok) begin
                        if (sel_rate == cur_rate_q) begin
                            sel_ack_d = 1'b1;
                        end else begin
                            pend_d  = sel_rate;
                            busy_d  = 1'b1;
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                if (!en) begin
                    cur_rate_d = pend_q;
                    sel_ack_d  = 1'b1;
                    busy_d     = 1'b0;
                    cnt_d      = '0;
                    state_d    = STOP;
                end else if (wrap) begin
                    // Switch only at a period boundary so no interval is cut short.
                    tick_d     = 1'b1;
                    cur_rate_d = pend_q;
                    sel_ack_d  = 1'b1;
                    busy_d     = 1'b0;
                    cnt_d      = '0;
                    state_d    = RUN;
                end else begin
                    cnt_d = cnt_next;
                end
            end
            default: begin
                state_d = STOP;
                cnt_d   = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= STOP;
            cnt_q      <= '0;
            cur_rate_q <= '0;
            pend_q     <= '0;
            tick_q     <= 1'b0;
            sel_ack_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_rate_q <= cur_rate_d;
            pend_q     <= pend_d;
            tick_q     <= tick_d;
            sel_ack_q  <= sel_ack_d;
            busy_q     <= busy_d;
        end
    end

    assign tick     = tick_q;
    assign sel_ack  = sel_ack_q;
    assign cur_rate = cur_rate_q;
    assign busy     = busy_q;

`ifdef TICK_RATE_CTRL_TICK_CNT_EN
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;

    always_comb begin
        tick_cnt_d = tick_q ? tick_cnt_q + 1'b1 : tick_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tick_cnt_q <= '0;
        else     tick_cnt_q <= tick_cnt_d;
    end

    assign tick_cnt = tick_cnt_q;
`else
    // TICK_W only sizes the tick counter; nothing is built without it.
    if (TICK_W > 0) begin : g_no_tick_cnt
    end
`endif

endmodule

// File: tb/tb_tick_rate_ctrl.sv
// Directed bench for tick_rate_ctrl: vector table plus multi-cycle rate-change sequences.
// Define TICK_RATE_CTRL_TICK_CNT_EN to also exercise the tick counter.
module tb_tick_rate_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       sel_req = 1'b0;
    logic [1:0] sel_rate = 2'd0;
    logic       sel_ack;
    logic       tick;
    logic [1:0] cur_rate;
    logic       busy;
`ifdef TICK_RATE_CTRL_TICK_CNT_EN
    logic [7:0] tick_cnt;
`endif

    int checks = 0;
    int failures = 0;

    tick_rate_ctrl #(.TICK_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sel_req  (sel_req),
        .sel_rate (sel_rate),
        .sel_ack  (sel_ack),
        .tick     (tick),
        .cur_rate (cur_rate),
        .busy     (busy)
`ifdef TICK_RATE_CTRL_TICK_CNT_EN
        ,
        .tick_cnt (tick_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; en = 1'b0; sel_req = 1'b0; sel_rate = 2'd0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Select a rate from STOP, then start running; returns after the RUN entry edge.
    task automatic select_and_run(input logic [1:0] rate);
        @(negedge clk);
        en = 1'b0; sel_req = 1'b1; sel_rate = rate;
        @(posedge clk); #1;
        check("sel_from_stop_ack", sel_ack, 1);
        @(negedge clk);
        sel_req = 1'b0; en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic wait_tick(input string name);
        int n;
        n = 0;
        while (!tick && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!tick) check(name, 0, 1);
    endtask

    typedef struct {
        logic       en;
        logic       req;
        logic [1:0] rate;
        logic       tick;
        logic       ack;
        logic [1:0] cur;
        logic       busy;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int n;
        // STOP select /2, run, same-rate request mid-run, stop, reselect /10.
        vecs[0]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 2'd1, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 2'd1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 2'd0, 1'b1, 1'b0, 2'd1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 2'd1, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 2'd1, 1'b1, 1'b1, 2'd1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 2'd1, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 2'd1, 1'b1, 1'b0, 2'd1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 2'd1, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 2'd2, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 2'd2, 1'b0};

        #1;
        check("reset_tick", tick, 0);
        check("reset_ack", sel_ack, 0);
        check("reset_rate", cur_rate, 0);
        check("reset_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            en = vecs[i].en; sel_req = vecs[i].req; sel_rate = vecs[i].rate;
            @(posedge clk); #1;
            check($sformatf("vec%0d_tick", i), tick, vecs[i].tick);
            check($sformatf("vec%0d_ack", i), sel_ack, vecs[i].ack);
            check($sformatf("vec%0d_rate", i), cur_rate, vecs[i].cur);
            check($sformatf("vec%0d_busy", i), busy, vecs[i].busy);
        end

        // /50 from STOP: first tick 50 cycles after RUN entry, then every 50.
        do_reset();
        select_and_run(2'd3);
        for (int k = 0; k < 2; k++) begin
            n = 0;
            do begin
                @(posedge clk); #1;
                n++;
            end while (!tick && n < 200);
            check($sformatf("div50_spacing%0d", k), n, 50);
        end

        // /10 -> /1 requested so it is accepted as cnt steps 2->3.
        do_reset();
        select_and_run(2'd2);
        wait_tick("div10_first_tick_timeout");
        repeat (2) @(posedge clk);
        @(negedge clk);
        sel_req = 1'b1; sel_rate = 2'd0;
        @(posedge clk); #1;
        check("drain_busy_set", busy, 1);
        n = 1;
        while (n < 100) begin
            @(posedge clk); #1;
            if (!busy) break;
            n++;
            check("drain_no_early_tick", tick, 0);
        end
        check("drain_busy_cycles", n, 7);
        check("drain_end_tick", tick, 1);
        check("drain_end_ack", sel_ack, 1);
        check("drain_end_rate", cur_rate, 0);
        @(negedge clk);
        sel_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check($sformatf("div1_tick%0d", k), tick, 1);
            check($sformatf("div1_noack%0d", k), sel_ack, 0);
        end

        // Drop en during /50 -> /2 drain at cnt=20.
        do_reset();
        select_and_run(2'd3);
        wait_tick("div50_first_tick_timeout");
        @(negedge clk);
        sel_req = 1'b1; sel_rate = 2'd1;
        @(posedge clk); #1;
        check("drain_en_busy", busy, 1);
        repeat (19) @(posedge clk);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk); #1;
        check("drain_en_tick", tick, 0);
        check("drain_en_ack", sel_ack, 1);
        check("drain_en_rate", cur_rate, 1);
        check("drain_en_busy_clr", busy, 0);
        @(negedge clk);
        sel_req = 1'b0;
        @(posedge clk); #1;
        check("stop_after_drain_tick", tick, 0);
        check("stop_after_drain_ack", sel_ack, 0);

        // Asynchronous reset during drain discards the pending request.
        do_reset();
        select_and_run(2'd3);
        wait_tick("div50_rst_tick_timeout");
        @(negedge clk);
        sel_req = 1'b1; sel_rate = 2'd2;
        @(posedge clk); #1;
        check("rst_drain_busy", busy, 1);
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        rst = 1'b1; sel_req = 1'b0; en = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_rate", cur_rate, 0);
        check("async_rst_ack", sel_ack, 0);
        check("async_rst_tick", tick, 0);
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            if (sel_ack || cur_rate != 2'd0) n++;
        end
        check("post_rst_quiet", n, 0);

`ifdef TICK_RATE_CTRL_TICK_CNT_EN
        do_reset();
        @(negedge clk);
        en = 1'b1;
        n = 0;
        for (int k = 0; k < 1000 && n < 300; k++) begin
            @(posedge clk); #1;
            if (tick) n++;
        end
        check("tick_cnt_300_seen", n, 300);
        @(negedge clk);
        en = 1'b0;
        @(posedge clk); #1;
        check("tick_cnt_wrap", tick_cnt, 44);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
